// File: rtl/spi_shift_register.sv
// SPI master serial datapath: shifts a loaded byte out on mosi and assembles a byte from miso,
// advancing one bit per strobe from the baud rate generator.
module spi_shift_register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Pclk,
  input  logic             PRESET,
  input  logic             ss,
  input  logic             send_data,
  input  logic [WIDTH-1:0] data_mosi,
  input  logic             lsbfe,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             mosi_send_sclk,
  input  logic             mosi_send_sclk0,
  input  logic             miso_recieve_sclk,
  input  logic             miso_recieve_sclk0,
  input  logic             miso,
  output logic             mosi,
  output logic [WIDTH-1:0] data_miso,
  output logic             spif,
  output logic             busy
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned CntW = IdxW + 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_reg_q, tx_reg_d;
  logic [WIDTH-1:0] rx_reg_q, rx_reg_d;
  logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
  logic             lsbfe_q, lsbfe_d;
  logic             mode_b_q, mode_b_d;
  logic             mosi_q, mosi_d;
  logic [WIDTH-1:0] data_miso_q, data_miso_d;
  logic             spif_q, spif_d;

  logic load, tx_stb, rx_stb, rx_last;

  // Bit position within the frame for a given count, honouring the latched bit order.
  function automatic logic [IdxW-1:0] bit_idx(input logic [IdxW-1:0] cnt, input logic lsb);
    return lsb ? cnt : IdxW'(WIDTH - 1) - cnt;
  endfunction

  assign load    = send_data && !ss;
  assign tx_stb  = mode_b_q ? mosi_send_sclk0 : mosi_send_sclk;
  assign rx_stb  = mode_b_q ? miso_recieve_sclk0 : miso_recieve_sclk;
  assign rx_last = (rx_cnt_q == CntW'(WIDTH - 1));

  // State register
  always_ff @(posedge Pclk or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ss abort takes priority over a completing receive strobe
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StShift;
      StShift: if (ss || (rx_stb && rx_last)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM output
  always_comb begin
    busy = (state_q == StShift);
  end

  // Datapath next-state
  always_comb begin
    tx_reg_d    = tx_reg_q;
    rx_reg_d    = rx_reg_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    lsbfe_d     = lsbfe_q;
    mode_b_d    = mode_b_q;
    mosi_d      = mosi_q;
    data_miso_d = data_miso_q;
    spif_d      = 1'b0;
    if (state_q == StIdle) begin
      if (load) begin
        tx_reg_d = data_mosi;
        rx_reg_d = '0;
        tx_cnt_d = '0;
        rx_cnt_d = '0;
        lsbfe_d  = lsbfe;
        mode_b_d = cpol ^ cpha;
      end
    end else if (ss) begin
      tx_cnt_d = '0;
      rx_cnt_d = '0;
    end else begin
      if (tx_stb && (tx_cnt_q < CntW'(WIDTH))) begin
        mosi_d   = tx_reg_q[bit_idx(tx_cnt_q[IdxW-1:0], lsbfe_q)];
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
      if (rx_stb) begin
        rx_reg_d[bit_idx(rx_cnt_q[IdxW-1:0], lsbfe_q)] = miso;
        if (rx_last) begin
          // Final bit is folded in during the completing cycle
          data_miso_d = rx_reg_d;
          spif_d      = 1'b1;
          rx_cnt_d    = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Pclk or posedge PRESET) begin
    if (PRESET) begin
      tx_reg_q    <= '0;
      rx_reg_q    <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      lsbfe_q     <= 1'b0;
      mode_b_q    <= 1'b0;
      mosi_q      <= 1'b0;
      data_miso_q <= '0;
      spif_q      <= 1'b0;
    end else begin
      tx_reg_q    <= tx_reg_d;
      rx_reg_q    <= rx_reg_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      lsbfe_q     <= lsbfe_d;
      mode_b_q    <= mode_b_d;
      mosi_q      <= mosi_d;
      data_miso_q <= data_miso_d;
      spif_q      <= spif_d;
    end
  end

  assign mosi      = mosi_q;
  assign data_miso = data_miso_q;
  assign spif      = spif_q;

endmodule

// File: tb/tb_spi_shift_register.sv
// Randomized bench for spi_shift_register; expected serial bits and received bytes come from
// a frame-level model (bit order and mode applied to whole bytes).
module tb_spi_shift_register;

  logic       Pclk = 1'b0;
  logic       PRESET, ss, send_data, lsbfe, cpol, cpha;
  logic       ms, ms0, mr, mr0, miso;
  logic [7:0] data_mosi;
  logic       mosi, spif, busy;
  logic [7:0] data_miso;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_miso = 8'h00;

  spi_shift_register #(.WIDTH(8)) dut (
    .Pclk              (Pclk),
    .PRESET            (PRESET),
    .ss                (ss),
    .send_data         (send_data),
    .data_mosi         (data_mosi),
    .lsbfe             (lsbfe),
    .cpol              (cpol),
    .cpha              (cpha),
    .mosi_send_sclk    (ms),
    .mosi_send_sclk0   (ms0),
    .miso_recieve_sclk (mr),
    .miso_recieve_sclk0(mr0),
    .miso              (miso),
    .mosi              (mosi),
    .data_miso         (data_miso),
    .spif              (spif),
    .busy              (busy)
  );

  always #5 Pclk = ~Pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Pclk);
  endtask

  // Drive the selected strobe pair; the other pair gets random noise that must be ignored
  task automatic set_strobes(input logic mb, input logic snd, input logic rcv);
    if (mb) begin
      ms0 = snd; mr0 = rcv; ms = 1'($urandom); mr = 1'($urandom);
    end else begin
      ms = snd; mr = rcv; ms0 = 1'($urandom); mr0 = 1'($urandom);
    end
  endtask

  task automatic do_load(input logic [7:0] d, input logic cp, input logic ch, input logic lsb);
    ss = 1'b0; send_data = 1'b1; data_mosi = d; cpol = cp; cpha = ch; lsbfe = lsb;
    ms = 0; ms0 = 0; mr = 0; mr0 = 0;
    tick();
    send_data = 1'b0;
    // Mode and order are latched; scramble the live inputs
    data_mosi = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); lsbfe = 1'($urandom);
    check_eq("busy_after_load", busy, 1);
    check_eq("spif_after_load", spif, 0);
  endtask

  // abort_at: -1 none, 0..7 raise ss before receive strobe k, 8 raise ss with final strobe
  task automatic run_frame(input logic [7:0] d, input logic [7:0] r, input logic mb,
                           input logic lsb, input int abort_at, input bit inject_load);
    logic exp_bit;
    for (int k = 0; k < 8; k++) begin
      set_strobes(mb, 1'b1, 1'b0);
      if (inject_load && k == 2) begin
        send_data = 1'b1; data_mosi = 8'hFF;
      end
      tick();
      set_strobes(mb, 1'b0, 1'b0);
      send_data = 1'b0;
      exp_bit = lsb ? d[k] : d[7-k];
      check_eq($sformatf("mosi_bit%0d", k), mosi, exp_bit);
      if (abort_at == k) begin
        ss = 1'b1;
        tick();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_spif", spif, 0);
        check_eq("abort_data_miso", data_miso, exp_miso);
        ss = 1'b0;
        return;
      end
      miso = lsb ? r[k] : r[7-k];
      set_strobes(mb, 1'b0, 1'b1);
      if (abort_at == 8 && k == 7) ss = 1'b1;
      tick();
      set_strobes(mb, 1'b0, 1'b0);
      if (abort_at == 8 && k == 7) begin
        check_eq("lastabort_busy", busy, 0);
        check_eq("lastabort_spif", spif, 0);
        check_eq("lastabort_data_miso", data_miso, exp_miso);
        ss = 1'b0;
        return;
      end
      if (k < 7) begin
        check_eq("busy_mid", busy, 1);
        check_eq("spif_mid", spif, 0);
      end
    end
    exp_miso = r;
    check_eq("spif_done", spif, 1);
    check_eq("data_miso", data_miso, exp_miso);
    check_eq("busy_done", busy, 0);
  endtask

  initial begin
    logic [7:0] d, r;
    logic       cp, ch, lsb;
    PRESET = 1'b1; ss = 1'b1; send_data = 1'b0; data_mosi = 8'h00;
    lsbfe = 0; cpol = 0; cpha = 0; ms = 0; ms0 = 0; mr = 0; mr0 = 0; miso = 0;
    tick(); tick();
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_data_miso", data_miso, 0);
    check_eq("rst_spif", spif, 0);
    check_eq("rst_busy", busy, 0);
    PRESET = 1'b0;
    ss = 1'b0;

    // Strobes while idle do nothing
    ms = 1; ms0 = 1; mr = 1; mr0 = 1; miso = 1;
    tick();
    ms = 0; ms0 = 0; mr = 0; mr0 = 0;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_mosi", mosi, 0);

    // Mode 0, MSB first
    do_load(8'hA5, 1'b0, 1'b0, 1'b0);
    run_frame(8'hA5, 8'h3C, 1'b0, 1'b0, -1, 0);
    tick();
    check_eq("spif_one_cycle", spif, 0);

    // Mode 1, LSB first, *0 strobes
    do_load(8'h81, 1'b0, 1'b1, 1'b1);
    run_frame(8'h81, 8'hF0, 1'b1, 1'b1, -1, 0);

    // Abort after 4 receive strobes, then a clean frame
    do_load(8'hC3, 1'b0, 1'b0, 1'b0);
    run_frame(8'hC3, 8'h99, 1'b0, 1'b0, 4, 0);
    do_load(8'h55, 1'b1, 1'b1, 1'b0);
    run_frame(8'h55, 8'h6E, 1'b0, 1'b0, -1, 0);

    // ss rising together with the final receive strobe
    do_load(8'h3A, 1'b1, 1'b0, 1'b1);
    run_frame(8'h3A, 8'hB7, 1'b1, 1'b1, 8, 0);

    // Load request during an active frame is ignored
    do_load(8'h00, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 8'h4D, 1'b0, 1'b0, -1, 1);

    // Back-to-back frames, reload in the cycle of spif
    do_load(8'h12, 1'b0, 1'b0, 1'b0);
    run_frame(8'h12, 8'hE1, 1'b0, 1'b0, -1, 0);
    do_load(8'h34, 1'b0, 1'b0, 1'b1);
    run_frame(8'h34, 8'h2B, 1'b0, 1'b1, -1, 0);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom); r = 8'($urandom);
      cp = 1'($urandom); ch = 1'($urandom); lsb = 1'($urandom);
      do_load(d, cp, ch, lsb);
      run_frame(d, r, cp ^ ch, lsb, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : -1, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Asynchronous reset mid-frame
    do_load(8'hFF, 1'b0, 1'b0, 1'b0);
    ms = 1'b1;
    tick();
    ms = 1'b0;
    check_eq("pre_rst_mosi", mosi, 1);
    #2 PRESET = 1'b1;
    #1;
    check_eq("async_rst_mosi", mosi, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_spif", spif, 0);
    check_eq("async_rst_data_miso", data_miso, 0);
    tick();
    PRESET = 1'b0;
    mr = 1'b1; ms = 1'b1;
    tick();
    mr = 1'b0; ms = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_mosi", mosi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
